uart_tx_arbiter: RTL and testbench



---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART control slice: arbiter state encodings,
// frame width and the default baud divisor used by the top-level integration.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   // Data bits per UART frame
   localparam int UART_NBITS    = 8;
   // Baud-rate generator divisor for 9600 baud at the system clock
   localparam int BAUD_DIV_9600 = 326;
   // Width of requester index signals (supports up to 8 requesters)
   localparam int GRANT_W       = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin picker. Scans the request vector starting
// at (i_last+1) mod N, moving upward with wrap, and returns the first set bit.
//
// Ports:
//   i_req   in  N   request vector
//   i_last  in  IW  index of the previous winner
//   o_win   out IW  index of the selected requester (0 when none)
//   o_vld   out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int IW = 3
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [IW-1:0] o_win,
   output logic          o_vld
);

   always_comb begin
      int w_idx;
      w_idx = 0;
      o_win = '0;
      o_vld = 1'b0;
      // Walk offsets from farthest to nearest so the nearest hit after i_last
      // is the final assignment and therefore the winner.
      for (int k = N; k >= 1; k--) begin
         w_idx = (int'(i_last) + k) % N;
         for (int j = 0; j < N; j++) begin
            if (j == w_idx && i_req[j]) begin
               o_win = IW'(j);
               o_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among N requesters. In IDLE a round-robin pick
// chooses a requester, its byte is latched onto TxData and TxEn is raised.
// The frame ends on TxDone (Done pulse) or after TIMEOUT_CYC cycles (Timeout
// pulse); a GAP of GAP_CYC cycles with TxEn low then separates frames.
//
// Ports:
//   Clk      in   1    system clock
//   Rst_n    in   1    asynchronous active-low reset
//   Req      in   N    request levels, held until Ack
//   ReqData  in   8*N  byte for requester i at [8i+7:8i]
//   Ack      out  N    one-cycle pulse, byte of requester i latched
//   Done     out  N    one-cycle pulse, frame of requester i completed
//   Timeout  out  1    one-cycle pulse, frame aborted without TxDone
//   Busy     out  1    high whenever not IDLE
//   GrantId  out  3    current/last granted requester
//   TxEn     out  1    transmitter enable
//   TxData   out  8    byte to transmitter
//   TxDone   in   1    transmitter completion pulse
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int N           = 4,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic [N-1:0]            Req,
   input  logic [UART_NBITS*N-1:0] ReqData,
   output logic [N-1:0]            Ack,
   output logic [N-1:0]            Done,
   output logic                    Timeout,
   output logic                    Busy,
   output logic [GRANT_W-1:0]      GrantId,
   output logic                    TxEn,
   output logic [UART_NBITS-1:0]   TxData,
   input  logic                    TxDone
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GCNT_LAST = GW'(GAP_CYC - 1);

   arb_state_t              r_state;
   logic [GRANT_W-1:0]      r_last;
   logic [GRANT_W-1:0]      r_grant;
   logic [TW-1:0]           r_tcnt;
   logic [GW-1:0]           r_gcnt;
   logic [N-1:0]            r_ack;
   logic [N-1:0]            r_done;
   logic                    r_timeout;
   logic                    r_busy;
   logic                    r_txen;
   logic [UART_NBITS-1:0]   r_txdata;

   logic [GRANT_W-1:0]      w_win;
   logic                    w_vld;
   logic [UART_NBITS-1:0]   w_byte;
   logic [N-1:0]            w_ack_vec;
   logic [N-1:0]            w_done_vec;

   rr_priority_pick #(
      .N  (N),
      .IW (GRANT_W)
   ) u_pick (
      .i_req  (Req),
      .i_last (r_last),
      .o_win  (w_win),
      .o_vld  (w_vld)
   );

   // Winner byte select and one-hot decodes, written as compare loops so the
   // 3-bit index never needs to match the N-dependent array index width.
   always_comb begin
      w_byte     = '0;
      w_ack_vec  = '0;
      w_done_vec = '0;
      for (int i = 0; i < N; i++) begin
         if (w_win == GRANT_W'(i)) begin
            w_byte       = ReqData[i*UART_NBITS +: UART_NBITS];
            w_ack_vec[i] = 1'b1;
         end
         if (r_grant == GRANT_W'(i))
            w_done_vec[i] = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state   <= ST_IDLE;
         r_last    <= GRANT_W'(N - 1);
         r_grant   <= '0;
         r_tcnt    <= '0;
         r_gcnt    <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
         r_txen    <= 1'b0;
         r_txdata  <= '0;
      end else begin
         r_ack     <= '0;
         r_done    <= '0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_vld) begin
                  r_txdata <= w_byte;
                  r_ack    <= w_ack_vec;
                  r_grant  <= w_win;
                  r_last   <= w_win;
                  r_txen   <= 1'b1;
                  r_busy   <= 1'b1;
                  r_tcnt   <= '0;
                  r_state  <= ST_SEND;
               end
            end
            ST_SEND: begin
               // TxDone is checked first so it wins over the terminal count.
               if (TxDone) begin
                  r_done  <= w_done_vec;
                  r_txen  <= 1'b0;
                  r_gcnt  <= '0;
                  r_state <= ST_GAP;
               end else if (r_tcnt == TCNT_LAST) begin
                  r_timeout <= 1'b1;
                  r_txen    <= 1'b0;
                  r_gcnt    <= '0;
                  r_state   <= ST_GAP;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            ST_GAP: begin
               if (r_gcnt == GCNT_LAST) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gcnt <= r_gcnt + GW'(1);
               end
            end
            default: begin
               r_txen  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Ack     = r_ack;
   assign Done    = r_done;
   assign Timeout = r_timeout;
   assign Busy    = r_busy;
   assign GrantId = r_grant;
   assign TxEn    = r_txen;
   assign TxData  = r_txdata;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N=4, GAP_CYC=16, TIMEOUT_CYC=120).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int TMO = 120;

   logic           Clk = 1'b0;
   logic           Rst_n;
   logic [N-1:0]   Req;
   logic [8*N-1:0] ReqData;
   logic [N-1:0]   Ack;
   logic [N-1:0]   Done;
   logic           Timeout;
   logic           Busy;
   logic [2:0]     GrantId;
   logic           TxEn;
   logic [7:0]     TxData;
   logic           TxDone;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .N           (N),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Req     (Req),
      .ReqData (ReqData),
      .Ack     (Ack),
      .Done    (Done),
      .Timeout (Timeout),
      .Busy    (Busy),
      .GrantId (GrantId),
      .TxEn    (TxEn),
      .TxData  (TxData),
      .TxDone  (TxDone)
   );

   always #5 Clk = ~Clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h10; exp_b[1] = 8'h21; exp_b[2] = 8'h32; exp_b[3] = 8'h43;

      // ---------------- reset ----------------
      Rst_n   = 1'b0;
      Req     = '0;
      TxDone  = 1'b0;
      ReqData = {8'h43, 8'hA5, 8'h21, 8'h10};
      step(5);
      chk("rst_txen",    TxEn,    0);
      chk("rst_txdata",  TxData,  0);
      chk("rst_ack",     Ack,     0);
      chk("rst_done",    Done,    0);
      chk("rst_timeout", Timeout, 0);
      chk("rst_busy",    Busy,    0);
      chk("rst_grant",   GrantId, 0);
      Rst_n = 1'b1;
      step(3);
      chk("idle_busy", Busy, 0);
      chk("idle_txen", TxEn, 0);

      // ---------------- single request ----------------
      Req = 4'b0100;
      step(1);
      chk("s_ack",    Ack,     4'b0100);
      chk("s_txen",   TxEn,    1);
      chk("s_txdata", TxData,  8'hA5);
      chk("s_busy",   Busy,    1);
      chk("s_grant",  GrantId, 2);
      Req = '0;
      step(1);
      chk("s_ack_pulse", Ack, 0);
      step(98);
      chk("s_txen_hold", TxEn, 1);
      TxDone = 1'b1;
      step(1);
      TxDone = 1'b0;
      chk("s_done",    Done,    4'b0100);
      chk("s_txen_lo", TxEn,    0);
      chk("s_no_tmo",  Timeout, 0);
      step(1);
      chk("s_done_pulse", Done, 0);
      step(GAP - 2);
      chk("s_gap_busy", Busy, 1);
      chk("s_gap_txen", TxEn, 0);
      step(1);
      chk("s_gap_end", Busy, 0);

      // ---------------- fairness ----------------
      Rst_n = 1'b0;
      step(2);
      Rst_n   = 1'b1;
      ReqData = {8'h43, 8'h32, 8'h21, 8'h10};
      Req     = 4'b1111;
      for (int g = 0; g < 6; g++) begin
         n = 0;
         do begin
            step(1);
            n++;
         end while (Ack == 0 && n < 60);
         chk($sformatf("f%0d_ack_lat", g), n, (g == 0) ? 1 : GAP + 1);
         chk($sformatf("f%0d_ack", g),    Ack,     4'b0001 << (g % 4));
         chk($sformatf("f%0d_grant", g),  GrantId, g % 4);
         chk($sformatf("f%0d_data", g),   TxData,  exp_b[g % 4]);
         step(49);
         TxDone = 1'b1;
         step(1);
         TxDone = 1'b0;
         chk($sformatf("f%0d_done", g), Done, 4'b0001 << (g % 4));
      end
      Req = '0;
      step(GAP + 2);
      chk("f_idle", Busy, 0);

      // ---------------- timeout ----------------
      Req = 4'b0001;
      step(1);
      chk("t_ack", Ack, 4'b0001);
      Req = '0;
      n = 0;
      while (TxEn === 1'b1 && n < 300) begin
         n++;
         step(1);
      end
      chk("t_txen_len", n,       TMO);
      chk("t_pulse",    Timeout, 1);
      chk("t_no_done",  Done,    0);
      Req = 4'b0001;
      n = 0;
      do begin
         step(1);
         n++;
      end while (Ack == 0 && n < 60);
      chk("t_next_lat", n,   GAP + 1);
      chk("t_next_ack", Ack, 4'b0001);
      Req = '0;

      // ---------------- collision: TxDone on terminal count ----------------
      step(TMO - 1);
      chk("c_txen_term", TxEn, 1);
      TxDone = 1'b1;
      step(1);
      TxDone = 1'b0;
      chk("c_done",   Done,    4'b0001);
      chk("c_no_tmo", Timeout, 0);
      chk("c_txen",   TxEn,    0);
      // TxDone in GAP and in IDLE is ignored
      step(3);
      TxDone = 1'b1;
      step(1);
      TxDone = 1'b0;
      chk("c_gap_done", Done, 0);
      step(13);
      chk("c_idle", Busy, 0);
      TxDone = 1'b1;
      step(1);
      TxDone = 1'b0;
      chk("c_idle_done", Done, 0);
      chk("c_idle_busy", Busy, 0);

      // ---------------- reset mid-SEND ----------------
      Req = 4'b0001;
      step(1);
      chk("r_ack", Ack, 4'b0001);
      Req = '0;
      step(3);
      Rst_n = 1'b0;
      #1;
      chk("r_txen_async", TxEn,    0);
      chk("r_busy_async", Busy,    0);
      chk("r_data_async", TxData,  0);
      step(3);
      chk("r_no_done", Done, 0);
      Rst_n = 1'b1;
      Req   = 4'b0010;
      step(1);
      chk("r_ack1",  Ack,     4'b0010);
      chk("r_grant", GrantId, 1);
      chk("r_data",  TxData,  8'h21);
      Req = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
